// File: rtl/spi_master_link.sv
// spi_master_link
//   SPI mode-0 (CPOL=0, CPHA=0) master. Full-duplex transfer of one DATA_W-bit
//   word per transaction, MSB first. Words come in over a valid/ready handshake;
//   the word received in the same transaction is returned with a one-cycle
//   rx_valid strobe.
//
//   Optional feature macro: SPI_MASTER_BURST_EN
//     defined   : a new word may be accepted during the final cycle of the last
//                 LOW phase; the link then stays selected and goes straight to
//                 SETUP (no GAP), giving back-to-back words under one ss_n.
//     undefined : every word is framed by its own ss_n pulse and a GAP phase.
//
// Ports
//   clk, reset            system clock (rising edge), async active-high reset
//   tx_data/valid/ready   transmit word handshake (accept = valid & ready)
//   rx_data/rx_valid      received word, one-cycle strobe on update
//   spi_sclk/mosi/ss_n    link outputs (all registered)
//   spi_miso              link input from the slave
//
// Parameters
//   DATA_W  word width in bits (>= 2)
//   CLK_DIV SCLK half-period in clk cycles (>= 1)

module spi_master_link #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_ss_n
);

    localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BC_W = $clog2(DATA_W);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_TOP  = BC_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    state_t            state, state_n;
    logic [PH_W-1:0]   phase, phase_n;
    logic [BC_W-1:0]   bit_cnt, bit_n;
    logic [DATA_W-1:0] tx_sh, tx_sh_n;
    logic [DATA_W-1:0] rx_sh;
    logic              done;
    logic              rdy_n;
    logic              accept;
    logic              ph_last;

    assign accept  = tx_valid & tx_ready;
    assign ph_last = (phase == PH_LAST);

    // Next-state logic. Every output register is loaded from the *next* state,
    // so what the link shows in a cycle always matches the state of that cycle.
    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_cnt;
        tx_sh_n = tx_sh;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SETUP;
                    phase_n = '0;
                    bit_n   = BC_TOP;
                    tx_sh_n = tx_data;
                end
            end
            SETUP: begin
                if (ph_last) begin
                    state_n = HIGH;
                    phase_n = '0;
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            HIGH: begin
                if (ph_last) begin
                    state_n = LOW;
                    phase_n = '0;
                    // advance MOSI on entry to LOW, but the last bit holds
                    if (bit_cnt != '0)
                        tx_sh_n = {tx_sh[DATA_W-2:0], 1'b0};
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            LOW: begin
                if (ph_last) begin
                    phase_n = '0;
                    if (bit_cnt != '0) begin
                        state_n = HIGH;
                        bit_n   = bit_cnt - 1'b1;
                    end else begin
                        done = 1'b1;
`ifdef SPI_MASTER_BURST_EN
                        if (accept) begin
                            state_n = SETUP;
                            bit_n   = BC_TOP;
                            tx_sh_n = tx_data;
                        end else begin
                            state_n = GAP;
                        end
`else
                        state_n = GAP;
`endif
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            GAP: begin
                if (ph_last) begin
                    state_n = IDLE;
                    phase_n = '0;
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
            end
        endcase

        rdy_n = (state_n == IDLE);
`ifdef SPI_MASTER_BURST_EN
        // open a slot for the next word in the final cycle of the last LOW
        rdy_n = rdy_n || (state_n == LOW && phase_n == PH_LAST && bit_n == '0);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            tx_ready <= 1'b1;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_ss_n <= 1'b1;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_n;
            tx_sh   <= tx_sh_n;
            // sample MISO on the edge that ends the first SCLK-high cycle
            if (state == HIGH && phase == '0)
                rx_sh <= {rx_sh[DATA_W-2:0], spi_miso};
            rx_valid <= done;
            if (done)
                rx_data <= rx_sh;
            tx_ready <= rdy_n;
            spi_sclk <= (state_n == HIGH);
            spi_ss_n <= !(state_n == SETUP || state_n == HIGH || state_n == LOW);
            spi_mosi <= tx_sh_n[DATA_W-1];
        end
    end

endmodule

// File: doc/spi_master_link.md
# spi_master_link

SPI mode-0 master that drives the four-wire link the vision subsystem exposes as an SPI slave (MOSI/SCLK/SS_n in, MISO out). Full-duplex transfer of one DATA_W-bit word per transaction, MSB first. Used on the companion side of the rover link and as the bus-functional driver in the vision system's integration bench. Accepts words over a valid/ready handshake and returns the simultaneously received word with a one-cycle valid strobe.

## Interface
- DATA_W, 16: word width in bits (≥2).
- CLK_DIV, 4: SCLK half-period in clk cycles (≥1).
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_W  word to transmit; captured on accept.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  master can accept a word; accept = tx_valid & tx_ready at a clk edge.
- rx_data  out  DATA_W  last received word; holds until next rx_valid.
- rx_valid  out  1  one-cycle strobe, rx_data updated.
- spi_sclk  out  1  serial clock, idle low (CPOL=0).
- spi_mosi  out  1  master data out.
- spi_miso  in  1  slave data in.
- spi_ss_n  out  1  active-low slave select.

## Operation
- States: IDLE, SETUP, HIGH, LOW, GAP. Each of SETUP/HIGH/LOW/GAP lasts exactly CLK_DIV clk cycles (phase counter).
- IDLE: tx_ready=1, ss_n=1, sclk=0. On accept, tx_data loaded into shift register, bit counter=DATA_W-1, go SETUP.
- SETUP: ss_n=0, sclk=0, mosi=word MSB. Then HIGH.
- HIGH: sclk=1. spi_miso sampled into rx shift register on the edge ending the first HIGH cycle. Then LOW.
- LOW: sclk=0; mosi advances to next bit on entry, except after the last bit (mosi holds). If bits remain, back to HIGH; else word complete.
- Word complete: next cycle rx_valid=1, rx_data=received word, ss_n=1, enter GAP. GAP: tx_ready=0, ss_n=1. Then IDLE.
- tx_data changes after accept are ignored. tx_ready=0 in all states except IDLE (and burst slot, see Configuration).
- All outputs registered; no combinational path from spi_miso or tx_valid to any output.

## Timing
- Reset values (asynchronous, immediate): state IDLE, tx_ready=1, rx_valid=0, rx_data=0, spi_sclk=0, spi_mosi=0, spi_ss_n=1. Reset mid-word aborts the transfer; no rx_valid is produced for it.
- Accept at edge T: ss_n falls at cycle T+1; first SCLK rise at T+1+CLK_DIV.
- rx_valid at T+1+CLK_DIV·(1+2·DATA_W); tx_ready high again at T+1+CLK_DIV·(2+2·DATA_W).
- SCLK period 2·CLK_DIV clk cycles, 50% duty; MOSI stable ≥CLK_DIV cycles before and after each rising edge.
- Exactly DATA_W rising SCLK edges per word.

## Configuration
- SPI_MASTER_BURST_EN defined: tx_ready also asserts during the final cycle of the last LOW phase. If accepted there, ss_n stays low, rx_valid still pulses next cycle for the finished word, new MSB driven on mosi and state goes to SETUP (no GAP). Consecutive rx_valid strobes are CLK_DIV·(1+2·DATA_W) cycles apart.
- Undefined: every word is framed by its own ss_n pulse with a GAP of CLK_DIV cycles; tx_ready only in IDLE.

## Test plan
- DATA_W=8, CLK_DIV=2, send 0xA5, slave model returns 0x3C -> MOSI at rising edges 1,0,1,0,0,1,0,1; rx_data=0x3C with rx_valid at T+35; tx_ready at T+37; 8 SCLK rises.
- Same config, tx_valid held high with 0x11 then 0x22, burst off -> ss_n high for exactly 2 cycles + IDLE accept cycle between words (3 cycles); both words received correctly.
- Burst on, 0x01 then 0x02 held valid -> ss_n low continuously across 16 SCLK rises; rx_valid strobes 34 cycles apart.
- CLK_DIV=1, DATA_W=16, send 0xFFFF with miso=0 -> SCLK period 2 cycles, rx_data=0x0000, rx_valid at T+34.
- Assert reset during bit 3 of 0xA5 -> outputs immediately at reset values, no rx_valid; after release send 0x5A -> clean transfer, rx_data matches slave.
- Change tx_data to 0x00 one cycle after accepting 0xC3 -> MOSI still shifts 0xC3.
